signal_conflict_monitor: RTL and testbench

Independent safety monitor on the field side of the intersection lamp bus. It samples the 16 lamp drives (approaches A/B/C, left-turn and right-turn arrows), and detects conflicting greens, illegal lamp combinations, short greens and a frozen controller. On a fault it latches a fault code and drives a flashing-red override until it is cleared.

---
 rtl/signal_conflict_monitor.sv | 198 +++++++++++++++++++
 tb/tb_signal_conflict_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/signal_conflict_monitor.sv
// Field-side safety monitor for the intersection lamp bus: samples the 16 lamp drives, flags
// conflicting greens, illegal lamp combinations, short greens and a frozen controller.
module signal_conflict_monitor #(
  parameter int START_HOLD = 4,
  parameter int BLANK_TOL  = 2,
  parameter int MIN_GREEN  = 8,
  parameter int MAX_STUCK  = 64,
  parameter int FLASH_DIV  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       CLEAR,
  input  logic       GA,
  input  logic       YA,
  input  logic       RA,
  input  logic       LA,
  input  logic       GB,
  input  logic       YB,
  input  logic       RB,
  input  logic       LB,
  input  logic       GC,
  input  logic       YC,
  input  logic       RC,
  input  logic       LC,
  input  logic       RL,
  input  logic       GL,
  input  logic       RR,
  input  logic       GR,
  output logic       FAULT,
  output logic [2:0] FAULT_CODE,
  output logic       FLASH_R,
  output logic       ACTIVE
);

  localparam int HW = (START_HOLD > 0) ? $clog2(START_HOLD + 1) : 1;
  localparam int BW = (BLANK_TOL > 0) ? $clog2(BLANK_TOL + 1) : 1;
  localparam int GW = (MIN_GREEN > 0) ? $clog2(MIN_GREEN + 1) : 1;
  localparam int SW = (MAX_STUCK > 0) ? $clog2(MAX_STUCK + 1) : 1;
  localparam int FW = (FLASH_DIV > 0) ? $clog2(FLASH_DIV + 1) : 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'((START_HOLD > 0) ? START_HOLD - 1 : 0);
  localparam logic [BW-1:0] BLANK_MAX  = BW'(BLANK_TOL);
  localparam logic [GW-1:0] GREEN_MAX  = GW'(MIN_GREEN);
  localparam logic [SW-1:0] STUCK_MAX  = SW'(MAX_STUCK);
  localparam logic [FW-1:0] FLASH_LAST = FW'((FLASH_DIV > 0) ? FLASH_DIV - 1 : 0);

  typedef enum logic [1:0] {ST_STARTUP, ST_MONITOR, ST_FAULT} state_t;

  state_t             state_q, state_d;
  logic [15:0]        s_q, s_d, p_q, p_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [BW-1:0]      blank_cnt_q, blank_cnt_d;
  logic [2:0][GW-1:0] green_cnt_q, green_cnt_d;
  logic [SW-1:0]      stuck_cnt_q, stuck_cnt_d;
  logic [FW-1:0]      flash_cnt_q, flash_cnt_d;
  logic               fault_q, fault_d, flash_q, flash_d, active_q, active_d;
  logic [2:0]         code_q, code_d;

  logic [15:0] lamps;
  logic [2:0]  green_now, green_prev, short_cnt;
  logic        conflict, violation, integ_trip, short_trip, stuck_trip, any_trip;
  logic [2:0]  trip_code;

  function automatic logic one_hot3(input logic g, input logic y, input logic r);
    return (g | y | r) & ~(g & y) & ~(g & r) & ~(y & r);
  endfunction

  assign lamps = {GA, YA, RA, LA, GB, YB, RB, LB, GC, YC, RC, LC, RL, GL, RR, GR};

  // Check logic looks only at the registered samples S (s_q) and P (p_q)
  always_comb begin
    conflict   = ((s_q[15] | s_q[14]) & (s_q[11] | s_q[10] | s_q[7] | s_q[6]))
               | (s_q[2] & (s_q[15] | s_q[11]))
               | (s_q[0] & (s_q[11] | s_q[7]));
    violation  = ~one_hot3(s_q[15], s_q[14], s_q[13]) | ~one_hot3(s_q[11], s_q[10], s_q[9])
               | ~one_hot3(s_q[7], s_q[6], s_q[5]) | (s_q[3] == s_q[2]) | (s_q[1] == s_q[0]);
    integ_trip = violation && (blank_cnt_q >= BLANK_MAX);
    green_now  = {s_q[15], s_q[11], s_q[7]};
    green_prev = {p_q[15], p_q[11], p_q[7]};
    short_cnt  = '0;
    for (int i = 0; i < 3; i++) short_cnt[i] = (green_cnt_q[i] < GREEN_MAX);
    short_trip = |(green_prev & ~green_now & short_cnt);
    stuck_trip = (MAX_STUCK != 0) && (stuck_cnt_q == STUCK_MAX);
    any_trip   = conflict | integ_trip | short_trip | stuck_trip;
    if (conflict)        trip_code = 3'd1;
    else if (integ_trip) trip_code = 3'd2;
    else if (short_trip) trip_code = 3'd3;
    else                 trip_code = 3'd4;
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    p_d         = p_q;
    hold_cnt_d  = hold_cnt_q;
    blank_cnt_d = blank_cnt_q;
    green_cnt_d = green_cnt_q;
    stuck_cnt_d = stuck_cnt_q;
    flash_cnt_d = flash_cnt_q;
    fault_d     = fault_q;
    flash_d     = flash_q;
    active_d    = active_q;
    code_d      = code_q;

    // The flasher keeps running in FAULT even while the monitor is frozen
    if (state_q == ST_FAULT) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_d     = ~flash_q;
        flash_cnt_d = '0;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end

    if (!ENABLE) begin
      s_d         = lamps;
      p_d         = s_q;
      blank_cnt_d = !violation ? '0 : (blank_cnt_q == BLANK_MAX) ? blank_cnt_q : blank_cnt_q + 1'b1;
      stuck_cnt_d = (s_q != p_q) ? '0 : (stuck_cnt_q == STUCK_MAX) ? stuck_cnt_q : stuck_cnt_q + 1'b1;
      for (int i = 0; i < 3; i++) begin
        green_cnt_d[i] = !green_now[i] ? '0 :
                         (green_cnt_q[i] == GREEN_MAX) ? green_cnt_q[i] : green_cnt_q[i] + 1'b1;
      end

      case (state_q)
        ST_STARTUP: begin
          if (hold_cnt_q >= HOLD_LAST) begin
            state_d  = ST_MONITOR;
            active_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_MONITOR: begin
          if (any_trip) begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            code_d      = trip_code;
            flash_d     = 1'b1;
            flash_cnt_d = '0;
            active_d    = 1'b0;
          end
        end
        default: begin
          if (CLEAR) begin
            state_d     = ST_STARTUP;
            hold_cnt_d  = '0;
            blank_cnt_d = '0;
            green_cnt_d = '0;
            stuck_cnt_d = '0;
            flash_cnt_d = '0;
            fault_d     = 1'b0;
            flash_d     = 1'b0;
            active_d    = 1'b0;
            code_d      = 3'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_STARTUP;
      s_q         <= '0;
      p_q         <= '0;
      hold_cnt_q  <= '0;
      blank_cnt_q <= '0;
      green_cnt_q <= '0;
      stuck_cnt_q <= '0;
      flash_cnt_q <= '0;
      fault_q     <= 1'b0;
      flash_q     <= 1'b0;
      active_q    <= 1'b0;
      code_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      p_q         <= p_d;
      hold_cnt_q  <= hold_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      green_cnt_q <= green_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      fault_q     <= fault_d;
      flash_q     <= flash_d;
      active_q    <= active_d;
      code_q      <= code_d;
    end
  end

  assign FAULT      = fault_q;
  assign FAULT_CODE = code_q;
  assign FLASH_R    = flash_q;
  assign ACTIVE     = active_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor: lamp vectors with hand-computed outputs,
// checked by immediate assertions one edge + 1 time unit after each step.
module tb_signal_conflict_monitor;

  // Lamp vector bit order: {GA,YA,RA,LA, GB,YB,RB,LB, GC,YC,RC,LC, RL,GL,RR,GR}
  localparam logic [15:0] ALL_RED   = 16'h222A;
  localparam logic [15:0] ALL_RED_L = 16'h322A;
  localparam logic [15:0] A_GREEN   = 16'h822A;
  localparam logic [15:0] BC_GREEN  = 16'h288A;
  localparam logic [15:0] GA_GB     = 16'h882A;
  localparam logic [15:0] B_DARK    = 16'h202A;
  localparam logic [15:0] GL_GB     = 16'h2826;

  logic        clk, reset, enable, clear;
  logic [15:0] lamps;
  logic        fault, flash_r, active;
  logic [2:0]  fault_code;
  int          checks, failures;

  signal_conflict_monitor dut (
    .CLK(clk), .RESET(reset), .ENABLE(enable), .CLEAR(clear),
    .GA(lamps[15]), .YA(lamps[14]), .RA(lamps[13]), .LA(lamps[12]),
    .GB(lamps[11]), .YB(lamps[10]), .RB(lamps[9]),  .LB(lamps[8]),
    .GC(lamps[7]),  .YC(lamps[6]),  .RC(lamps[5]),  .LC(lamps[4]),
    .RL(lamps[3]),  .GL(lamps[2]),  .RR(lamps[1]),  .GR(lamps[0]),
    .FAULT(fault), .FAULT_CODE(fault_code), .FLASH_R(flash_r), .ACTIVE(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] lamp_v, input logic clr, input logic en,
                               input int cycles);
    lamps  = lamp_v;
    clear  = clr;
    enable = en;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    lamps    = ALL_RED;
    #1 reset = 1'b1;
    #2;
    checkOutput("reset_fault", {7'd0, fault}, 8'd0);
    checkOutput("reset_code", {5'd0, fault_code}, 8'd0);
    checkOutput("reset_flash", {7'd0, flash_r}, 8'd0);
    checkOutput("reset_active", {7'd0, active}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(ALL_RED, 1'b0, 1'b0, 3);
    checkOutput("startup_active_early", {7'd0, active}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("startup_active", {7'd0, active}, 8'd1);

    $display("[TB] legal cycle");
    applyStimulus(A_GREEN, 1'b0, 1'b0, 10);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 2);
    applyStimulus(BC_GREEN, 1'b0, 1'b0, 10);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 2);
    checkOutput("legal_fault", {7'd0, fault}, 8'd0);
    checkOutput("legal_active", {7'd0, active}, 8'd1);

    $display("[TB] conflict GA+GB");
    applyStimulus(GA_GB, 1'b0, 1'b0, 1);
    checkOutput("conflict_capture_edge", {7'd0, fault}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("conflict_fault", {7'd0, fault}, 8'd1);
    checkOutput("conflict_code", {5'd0, fault_code}, 8'd1);
    checkOutput("conflict_flash_entry", {7'd0, flash_r}, 8'd1);
    checkOutput("conflict_active_drop", {7'd0, active}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 3);
    checkOutput("flash_hold", {7'd0, flash_r}, 8'd1);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("flash_toggle_low", {7'd0, flash_r}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 4);
    checkOutput("flash_toggle_high", {7'd0, flash_r}, 8'd1);
    checkOutput("conflict_code_latched", {5'd0, fault_code}, 8'd1);

    applyStimulus(ALL_RED, 1'b1, 1'b0, 1);
    checkOutput("clear_fault", {7'd0, fault}, 8'd0);
    checkOutput("clear_code", {5'd0, fault_code}, 8'd0);
    checkOutput("clear_flash", {7'd0, flash_r}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 3);
    checkOutput("clear_active_early", {7'd0, active}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("clear_active", {7'd0, active}, 8'd1);

    $display("[TB] integrity blanking");
    applyStimulus(B_DARK, 1'b0, 1'b0, 2);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 3);
    checkOutput("blank2_no_fault", {7'd0, fault}, 8'd0);
    applyStimulus(B_DARK, 1'b0, 1'b0, 3);
    checkOutput("blank3_before_trip", {7'd0, fault}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("blank3_fault", {7'd0, fault}, 8'd1);
    checkOutput("blank3_code", {5'd0, fault_code}, 8'd2);

    $display("[TB] short green");
    applyStimulus(ALL_RED, 1'b1, 1'b0, 1);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 4);
    applyStimulus(A_GREEN, 1'b0, 1'b0, 5);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("short_before_trip", {7'd0, fault}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("short_fault", {7'd0, fault}, 8'd1);
    checkOutput("short_code", {5'd0, fault_code}, 8'd3);

    $display("[TB] conflict and short green together");
    applyStimulus(ALL_RED, 1'b1, 1'b0, 1);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 4);
    applyStimulus(A_GREEN, 1'b0, 1'b0, 5);
    applyStimulus(GL_GB, 1'b0, 1'b0, 1);
    checkOutput("prio_before_trip", {7'd0, fault}, 8'd0);
    applyStimulus(GL_GB, 1'b0, 1'b0, 1);
    checkOutput("prio_code", {5'd0, fault_code}, 8'd1);

    $display("[TB] stuck watchdog");
    applyStimulus(ALL_RED, 1'b1, 1'b0, 1);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 65);
    checkOutput("stuck_before_trip", {7'd0, fault}, 8'd0);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("stuck_fault", {7'd0, fault}, 8'd1);
    checkOutput("stuck_code", {5'd0, fault_code}, 8'd4);

    applyStimulus(ALL_RED_L, 1'b1, 1'b0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(i[0] ? ALL_RED_L : ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("moving_active_early", {7'd0, active}, 8'd0);
    applyStimulus(ALL_RED_L, 1'b0, 1'b0, 1);
    checkOutput("moving_active", {7'd0, active}, 8'd1);
    for (int i = 0; i < 70; i++) applyStimulus(i[0] ? ALL_RED_L : ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("moving_no_stuck", {7'd0, fault}, 8'd0);

    $display("[TB] freeze");
    applyStimulus(ALL_RED, 1'b0, 1'b1, 100);
    checkOutput("freeze_no_fault", {7'd0, fault}, 8'd0);
    checkOutput("freeze_active_hold", {7'd0, active}, 8'd1);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 3);
    checkOutput("unfreeze_no_fault", {7'd0, fault}, 8'd0);

    $display("[TB] reset during fault");
    applyStimulus(GA_GB, 1'b0, 1'b0, 1);
    applyStimulus(ALL_RED, 1'b0, 1'b0, 1);
    checkOutput("rst_pre_fault", {7'd0, fault}, 8'd1);
    applyStimulus(ALL_RED, 1'b0, 1'b1, 3);
    checkOutput("frozen_flash_hold", {7'd0, flash_r}, 8'd1);
    applyStimulus(ALL_RED, 1'b0, 1'b1, 1);
    checkOutput("frozen_flash_runs", {7'd0, flash_r}, 8'd0);
    checkOutput("frozen_fault_hold", {7'd0, fault}, 8'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_fault", {7'd0, fault}, 8'd0);
    checkOutput("async_rst_code", {5'd0, fault_code}, 8'd0);
    checkOutput("async_rst_flash", {7'd0, flash_r}, 8'd0);
    checkOutput("async_rst_active", {7'd0, active}, 8'd0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
